mac_pipe: RTL and testbench

Parametrised, pipelined multiply-add/multiply-accumulate unit. It generalises the registered A*B+C datapath:
- selectable width
- valid/ready handshake with back-pressure
- per-transaction accumulate mode with clear
- overflow reporting

It sits between a sample source and downstream filter/sum logic in the arithmetic datapath.

---
 rtl/mac_pkg.sv | 9 +
 rtl/sun_parameter.sv | 4 +
 rtl/mac_acc_stage.sv | 67 ++++++
 rtl/mac_pipe.sv | 97 +++++++++
 tb/tb_mac_pipe.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - mode encoding and accumulator guard-bit count for mac_pipe
package mac_pkg;
  typedef enum logic {
    MAC_MULADD = 1'b0,
    MAC_ACC    = 1'b1
  } mac_mode_t;

  localparam int ACC_GUARD = 4;
endpackage

// File: rtl/sun_parameter.sv
// rtl/sun_parameter.sv - default operand width shared by the arithmetic datapath
package sun_parameter;
  localparam int sun = 8;
endpackage

// File: rtl/mac_acc_stage.sv
// rtl/mac_acc_stage.sv - stage-2 add/clear/overflow logic and accumulator register
// MAC_SAT_EN: when defined, ACC overflow saturates to all ones instead of wrapping.
module mac_acc_stage
  import mac_pkg::*;
#(
  parameter int W     = 8,
  parameter int ACC_W = 2 * W + ACC_GUARD
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv,
  input  logic             s1_valid,
  input  mac_mode_t        mode,
  input  logic             clr,
  input  logic [2*W-1:0]   prod,
  input  logic [W-1:0]     addend,
  output logic [ACC_W-1:0] data_out,
  output logic             ovf
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] data_q, data_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] base;
  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] acc_res;

  always_comb begin
    base    = clr ? '0 : acc_q;
    sum     = {1'b0, base} + {{(ACC_W + 1 - 2 * W){1'b0}}, prod};
    acc_res = sum[ACC_W-1:0];
`ifdef MAC_SAT_EN
    if (sum[ACC_W]) acc_res = '1;
`else
`endif
    acc_d  = acc_q;
    data_d = data_q;
    ovf_d  = ovf_q;
    if (adv && s1_valid) begin
      if (mode == MAC_ACC) begin
        acc_d  = acc_res;
        data_d = acc_res;
        ovf_d  = sum[ACC_W];
      end else begin
        // Full-width add; ACC_W >= 2*W+1 guarantees no carry out.
        data_d = {{(ACC_W - 2 * W){1'b0}}, prod} + {{(ACC_W - W){1'b0}}, addend};
        ovf_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      data_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      data_q <= data_d;
      ovf_q  <= ovf_d;
    end
  end

  assign data_out = data_q;
  assign ovf      = ovf_q;

endmodule

// File: rtl/mac_pipe.sv
// rtl/mac_pipe.sv - two-stage multiply-add / multiply-accumulate with valid/ready
// MAC_SAT_EN (see mac_acc_stage) selects saturating ACC overflow.
module mac_pipe
  import mac_pkg::*;
#(
  parameter int W     = sun_parameter::sun,
  parameter int ACC_W = 2 * W + ACC_GUARD
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  input  logic             clr,
  input  logic [W-1:0]     A,
  input  logic [W-1:0]     B,
  input  logic [W-1:0]     C,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] DATA_OUT,
  output logic             ovf
);

  if (ACC_W < 2 * W + 1) begin : g_acc_w_check
    $error("mac_pipe: ACC_W must be >= 2*W+1");
  end

  logic            adv;
  logic            accept;
  logic            s1_valid_q, s1_valid_d;
  logic [2*W-1:0]  prod_q, prod_d;
  logic [W-1:0]    c_q, c_d;
  mac_mode_t       mode_q, mode_d;
  logic            clr_q, clr_d;
  logic            out_valid_q, out_valid_d;

  // Single global stall: the whole pipe freezes while a result waits.
  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv;
  assign accept   = in_valid && adv;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    prod_d      = prod_q;
    c_d         = c_q;
    mode_d      = mode_q;
    clr_d       = clr_q;
    out_valid_d = out_valid_q;
    if (adv) begin
      s1_valid_d  = accept;
      out_valid_d = s1_valid_q;
    end
    if (accept) begin
      prod_d = {{W{1'b0}}, A} * {{W{1'b0}}, B};
      c_d    = C;
      mode_d = mac_mode_t'(mode);
      clr_d  = clr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      prod_q      <= '0;
      c_q         <= '0;
      mode_q      <= MAC_MULADD;
      clr_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      prod_q      <= prod_d;
      c_q         <= c_d;
      mode_q      <= mode_d;
      clr_q       <= clr_d;
      out_valid_q <= out_valid_d;
    end
  end

  mac_acc_stage #(
    .W     (W),
    .ACC_W (ACC_W)
  ) u_acc_stage (
    .clk      (clk),
    .rst_n    (rst_n),
    .adv      (adv),
    .s1_valid (s1_valid_q),
    .mode     (mode_q),
    .clr      (clr_q),
    .prod     (prod_q),
    .addend   (c_q),
    .data_out (DATA_OUT),
    .ovf      (ovf)
  );

  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mac_pipe.sv
// tb/tb_mac_pipe.sv - directed self-checking bench for mac_pipe (W=8, ACC_W=20)
module tb_mac_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        mode;
  logic        clr;
  logic [7:0]  A, B, C;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] DATA_OUT;
  logic        ovf;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_acc_cyc;
  int t0;

  typedef struct {
    logic [19:0] d;
    logic        o;
    int          cyc;
  } res_t;
  res_t q[$];

  mac_pipe #(.W(8), .ACC_W(20)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .clr       (clr),
    .A         (A),
    .B         (B),
    .C         (C),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .DATA_OUT  (DATA_OUT),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (rst_n && out_valid && out_ready) q.push_back('{DATA_OUT, ovf, cyc});

  function automatic void check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send(input logic m, input logic cl, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] c);
    bit ok = 1'b0;
    int n  = 0;
    in_valid = 1'b1; mode = m; clr = cl; A = a; B = b; C = c;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = in_ready;
      last_acc_cyc = cyc;
      @(posedge clk);
      #2;
      n++;
    end
    in_valid = 1'b0;
    check("accept", ok, 1);
  endtask

  task automatic wait_results(input int n);
    int k = 0;
    while (q.size() < n && k < 100) begin
      step(1);
      k++;
    end
  endtask

  task automatic expect_out(input string tag, input logic [19:0] d, input logic o);
    res_t r;
    check({tag, "_present"}, q.size() > 0, 1);
    if (q.size() > 0) begin
      r = q.pop_front();
      check({tag, "_data"}, r.d, d);
      check({tag, "_ovf"}, r.o, o);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    mode = 1'b0; clr = 1'b0; A = '0; B = '0; C = '0;
    step(3);
    check("rst_out_valid", out_valid, 0);
    check("rst_data", DATA_OUT, 0);
    check("rst_ovf", ovf, 0);
    check("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    step(1);

    // Reset with two transactions in flight
    send(1'b1, 1'b1, 8'd9, 8'd9, 8'd0);
    send(1'b1, 1'b0, 8'd9, 8'd9, 8'd0);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_data", DATA_OUT, 0);
    check("midrst_ovf", ovf, 0);
    step(2);
    rst_n = 1'b1;
    step(5);
    check("midrst_no_emit", q.size(), 0);
    send(1'b1, 1'b0, 8'd2, 8'd3, 8'd0);
    wait_results(1);
    expect_out("acc_after_rst", 20'd6, 1'b0);

    // MULADD max and latency
    send(1'b0, 1'b0, 8'd255, 8'd255, 8'd255);
    t0 = last_acc_cyc;
    wait_results(1);
    if (q.size() > 0) check("latency", q[0].cyc - t0, 2);
    expect_out("muladd_max", 20'd65280, 1'b0);
    send(1'b0, 1'b0, 8'd1, 8'd2, 8'd3);
    send(1'b0, 1'b0, 8'd10, 8'd20, 8'd30);
    send(1'b0, 1'b0, 8'd255, 8'd0, 8'd7);
    send(1'b0, 1'b0, 8'd100, 8'd200, 8'd255);
    wait_results(4);
    if (q.size() >= 4) check("b2b_spacing", q[3].cyc - q[0].cyc, 3);
    expect_out("muladd0", 20'd5, 1'b0);
    expect_out("muladd1", 20'd230, 1'b0);
    expect_out("muladd2", 20'd7, 1'b0);
    expect_out("muladd3", 20'd20255, 1'b0);

    // ACC with clear
    send(1'b1, 1'b1, 8'd3, 8'd4, 8'd0);
    send(1'b1, 1'b0, 8'd5, 8'd6, 8'd0);
    send(1'b1, 1'b0, 8'd2, 8'd2, 8'd0);
    send(1'b1, 1'b1, 8'd1, 8'd1, 8'd0);
    wait_results(4);
    expect_out("acc0", 20'd12, 1'b0);
    expect_out("acc1", 20'd42, 1'b0);
    expect_out("acc2", 20'd46, 1'b0);
    expect_out("acc_clr", 20'd1, 1'b0);

    // Overflow
    for (int i = 0; i < 17; i++) send(1'b1, (i == 0), 8'd255, 8'd255, 8'd0);
    send(1'b1, 1'b0, 8'd1, 8'd1, 8'd0);
    wait_results(18);
    for (int i = 0; i < 16; i++) expect_out("acc_run", 20'((i + 1) * 65025), 1'b0);
`ifdef MAC_SAT_EN
    expect_out("acc_ovf", 20'd1048575, 1'b1);
    expect_out("acc_after_ovf", 20'd1048575, 1'b1);
`else
    expect_out("acc_ovf", 20'd56849, 1'b1);
    expect_out("acc_after_ovf", 20'd56850, 1'b0);
`endif

    // Back-pressure: out_ready low for 5 cycles
    out_ready = 1'b0;
    fork
      begin
        send(1'b1, 1'b1, 8'd1, 8'd2, 8'd0);
        send(1'b1, 1'b0, 8'd3, 8'd4, 8'd0);
        send(1'b1, 1'b0, 8'd5, 8'd6, 8'd0);
        send(1'b1, 1'b0, 8'd7, 8'd8, 8'd0);
        send(1'b1, 1'b0, 8'd9, 8'd10, 8'd0);
        send(1'b1, 1'b0, 8'd11, 8'd12, 8'd0);
      end
      begin
        step(3);
        check("bp_in_ready", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        check("bp_data", DATA_OUT, 2);
        for (int i = 0; i < 2; i++) begin
          step(1);
          check("bp_hold_data", DATA_OUT, 2);
          check("bp_hold_ready", in_ready, 0);
        end
        out_ready = 1'b1;
      end
    join
    wait_results(6);
    expect_out("bp0", 20'd2, 1'b0);
    expect_out("bp1", 20'd14, 1'b0);
    expect_out("bp2", 20'd44, 1'b0);
    expect_out("bp3", 20'd100, 1'b0);
    expect_out("bp4", 20'd190, 1'b0);
    expect_out("bp5", 20'd322, 1'b0);
    step(5);
    check("bp_no_dup", q.size(), 0);

    // Mixed modes; clr on MULADD is ignored
    send(1'b1, 1'b1, 8'd10, 8'd10, 8'd0);
    send(1'b0, 1'b1, 8'd2, 8'd3, 8'd1);
    send(1'b1, 1'b0, 8'd1, 8'd1, 8'd0);
    wait_results(3);
    expect_out("mix_acc0", 20'd100, 1'b0);
    expect_out("mix_muladd", 20'd7, 1'b0);
    expect_out("mix_acc1", 20'd101, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
